alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised, clocked successor to the 32-bit combinational ALU. It handles single-cycle arithmetic and logic operations, plus iterative signed multiply (shift-add) and signed divide (restoring) that take W+2 cycles. It replaces three parallel combinational datapaths with one registered datapath and a start/busy/done handshake. It sits in the execute stage; the control unit stalls on `busy`.

## Interface
- `W`, 32: operand width in bits; any value 4..64.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `start` input 1: begin operation; sampled only in IDLE.
- `FS` input 5: function select; latched with `start`.
- `S`, `T` input W: operands; latched with `start`.
- `busy` output 1: high while an iterative operation is in progress.
- `done` output 1: one-cycle pulse when results update.
- `Y_hi`, `Y_lo` output W: result. MUL: high/low product. DIV: remainder/quotient. Other ops: `Y_hi`=0, `Y_lo`=result.
- `C`, `V`, `N`, `Z` output 1: status flags, registered with the result.

## Operation
- Opcodes:
  - 00 PASS_S, 01 PASS_T
  - 02 ADD, 03 ADDU, 04 SUB, 05 SUBU
  - 06 SLT, 07 SLTU
  - 08 AND, 09 OR, 0A XOR, 0B NOR
  - 0C SLL, 0D SRL, 0E SRA: shift T by S[log2(W)-1:0]
  - 1E MUL (signed), 1F DIV (signed)
  - All other codes: Y=0, all flags 0, `done` still pulses.
- State machine: IDLE, MUL, DIV, FIX.
  - IDLE & start & single-cycle op: result and flags registered at that edge; `done`=1 for the next cycle; stays IDLE.
  - IDLE & start & MUL: latch |S|, |T| and the sign; counter=0; go to MUL.
  - MUL: add |S|<<i to the accumulator if bit i of |T| is set; after W iterations go to FIX.
  - IDLE & start & DIV with T≠0: same latching; go to DIV.
  - DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit); after W iterations go to FIX.
  - FIX: apply two's-complement negation. Product is negated if sign(S)^sign(T). Quotient is negated if sign(S)^sign(T); remainder takes the sign of S. Register outputs, pulse `done`, go to IDLE.
- Divide by zero (DIV with T=0): handled in IDLE in one cycle. Y_lo = all ones, Y_hi = S, V=1, C=0, N/Z per Y_lo.
- Flags:
  - ADD/SUB: C = carry out of bit W-1 (SUB carry = no borrow); V = signed overflow.
  - ADDU/SUBU: C as for ADD/SUB; V=0.
  - All other ops: C=0 and V=0, except DIV.
  - N = Y_lo[W-1] and Z = (Y_lo==0), except for MUL and DIV.
  - MUL: N = Y_hi[W-1], Z = ({Y_hi,Y_lo}==0).
  - DIV: N/Z computed on the quotient. V=1 on divide by zero or on (S=most negative, T=-1); in the latter case the quotient is the most negative value and the remainder is 0.
- `start` while `busy` is ignored; operands and FS are not re-latched.
- Outputs hold their last value until the next `done`.
- `reset` in any state: go to IDLE. All outputs and internal registers clear to 0: `busy`=0, `done`=0, Y_hi=Y_lo=0, C=V=N=Z=0. An in-flight operation is discarded with no `done`.

## Timing
- Single-cycle ops and divide by zero:
  - `start` sampled at edge k; results valid and `done`=1 during cycle k+1.
  - `busy` stays 0.
- MUL/DIV:
  - `start` sampled at edge k; `busy`=1 from cycle k+1 through cycle k+W+1.
  - FIX executes at edge k+W+1.
  - `done`=1 and results valid in cycle k+W+2; `busy`=0 in that same cycle.
  - Latency = W+2 cycles.
- Back-to-back: `start` may be high in the cycle where `done`=1. That edge is sampled in IDLE and accepted, giving a throughput of 1 op/cycle for single-cycle ops.
- `done` is never high for two consecutive cycles from a single operation.

## Configuration
- `ALU_DIV_EN` defined: the divider datapath and the DIV state are compiled in; opcode 1F behaves as specified above.
- `ALU_DIV_EN` undefined: the divider logic is removed. Opcode 1F becomes a single-cycle illegal op: Y_hi=Y_lo=0, V=1, other flags 0, `done` pulses at k+1, `busy` stays 0.

## Test plan
- W=32, ADD S=0x7FFFFFFF, T=1 -> at k+1: Y_lo=0x80000000, V=1, N=1, C=0, Z=0, `done` for one cycle.
- MUL S=-3, T=7 -> `busy` for 33 cycles; at k+34: {Y_hi,Y_lo}=0xFFFFFFFF_FFFFFFEB, N=1, Z=0.
- DIV S=-7, T=2 -> at k+34: Y_lo=0xFFFFFFFD (-3), Y_hi=0xFFFFFFFF (-1), N=1, V=0.
- DIV S=5, T=0 -> at k+1: Y_lo=0xFFFFFFFF, Y_hi=5, V=1, `busy` never asserted.
- Overflow and busy handling:
  - DIV S=0x80000000, T=-1 -> Y_lo=0x80000000, Y_hi=0, V=1.
  - Issue SUB `start` pulses while the divide is busy -> ignored; no extra `done`.
- `reset` asserted at cycle 10 of a MUL -> next cycle: `busy`=0 and all outputs 0. No `done` follows. A subsequent PASS_S with S=0x1234 returns Y_lo=0x1234 at k+1.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: start/busy/done handshake, operands and registered results of alu_multicycle
interface alu_multicycle_if #(parameter int W = 32);
  logic start, busy, done, C, V, N, Z;
  logic [4:0] FS;
  logic [W-1:0] S, T, Y_hi, Y_lo;
  modport master(output start, FS, S, T, input busy, done, Y_hi, Y_lo, C, V, N, Z);
  modport slave(input start, FS, S, T, output busy, done, Y_hi, Y_lo, C, V, N, Z);
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with iterative signed shift-add MUL and restoring DIV.
// Define ALU_DIV_EN to build the divider; otherwise opcode 1F is a single-cycle illegal op.
module alu_multicycle #(parameter int W = 32) (
  input logic clk,
  input logic reset,
  alu_multicycle_if.slave bus
);
  localparam int SW = $clog2(W);
`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, FIX, DIV} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;
`endif
  state_t state, state_n;
  logic [W-1:0] s, t, abs_s, abs_t, a, hi, lo, sc_hi, sc_lo, y_hi, y_lo;
  logic [W:0] add_r, sub_r, mul_sum;
  logic [2*W-1:0] prod;
  logic [SW-1:0] cnt;
  logic sc_c, sc_v, sc_ok, neg, c, v, n, z, done, mul_go, last;
  assign s = bus.S;
  assign t = bus.T;
  assign abs_s = s[W-1] ? -s : s;
  assign abs_t = t[W-1] ? -t : t;
  assign add_r = {1'b0, s} + {1'b0, t};
  assign sub_r = {1'b0, s} + {1'b0, ~t} + 1'b1;
  assign mul_go = bus.start && bus.FS == 5'h1E;
  assign last = cnt == SW'(W - 1);
  // hi accumulates the partial product while lo shifts the multiplier out
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
  assign prod = neg ? -{hi, lo} : {hi, lo};
`ifdef ALU_DIV_EN
  logic [W-1:0] r2, q_fix, r_fix;
  logic [W:0] dif;
  logic div_go, sgn_s, ovf, is_div;
  assign div_go = bus.start && bus.FS == 5'h1F && |t;
  // hi is the partial remainder, always below the divisor, so its MSB is zero
  assign r2 = {hi[W-2:0], lo[W-1]};
  assign dif = {1'b0, r2} - {1'b0, a};
  assign q_fix = neg ? -lo : lo;
  assign r_fix = sgn_s ? -hi : hi;
`endif
  always_comb begin
    sc_hi = '0;
    sc_lo = '0;
    sc_c = 1'b0;
    sc_v = 1'b0;
    sc_ok = 1'b1;
    case (bus.FS)
      5'h00: sc_lo = s;
      5'h01: sc_lo = t;
      5'h02, 5'h03: {sc_c, sc_lo} = add_r;
      5'h04, 5'h05: {sc_c, sc_lo} = sub_r;
      5'h06: sc_lo = W'($signed(s) < $signed(t));
      5'h07: sc_lo = W'(s < t);
      5'h08: sc_lo = s & t;
      5'h09: sc_lo = s | t;
      5'h0A: sc_lo = s ^ t;
      5'h0B: sc_lo = ~(s | t);
      5'h0C: sc_lo = t << s[SW-1:0];
      5'h0D: sc_lo = t >> s[SW-1:0];
      5'h0E: sc_lo = $signed(t) >>> s[SW-1:0];
`ifdef ALU_DIV_EN
      5'h1F: begin sc_hi = s; sc_lo = '1; sc_v = 1'b1; end
`else
      5'h1F: begin sc_ok = 1'b0; sc_v = 1'b1; end
`endif
      default: sc_ok = 1'b0;
    endcase
    if (bus.FS == 5'h02) sc_v = s[W-1] == t[W-1] && sc_lo[W-1] != s[W-1];
    if (bus.FS == 5'h04) sc_v = s[W-1] != t[W-1] && sc_lo[W-1] != s[W-1];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (mul_go) state_n = MUL;
`ifdef ALU_DIV_EN
        else if (div_go) state_n = DIV;
      DIV: if (last) state_n = FIX;
`endif
      MUL: if (last) state_n = FIX;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      a <= '0;
      hi <= '0;
      lo <= '0;
      neg <= 1'b0;
      y_hi <= '0;
      y_lo <= '0;
      {c, v, n, z} <= '0;
      done <= 1'b0;
`ifdef ALU_DIV_EN
      {sgn_s, ovf, is_div} <= '0;
`endif
    end else begin
      state <= state_n;
      done <= 1'b0;
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          hi <= '0;
          a <= mul_go ? abs_s : abs_t;
          lo <= mul_go ? abs_t : abs_s;
          neg <= s[W-1] ^ t[W-1];
`ifdef ALU_DIV_EN
          sgn_s <= s[W-1];
          is_div <= !mul_go;
          ovf <= s == {1'b1, {(W-1){1'b0}}} && &t;
`endif
          if (bus.start && state_n == IDLE) begin
            y_hi <= sc_hi;
            y_lo <= sc_lo;
            {c, v, n, z} <= {sc_c, sc_v, sc_ok & sc_lo[W-1], sc_ok & ~|sc_lo};
            done <= 1'b1;
          end
        end
        MUL: {hi, lo} <= {mul_sum, lo[W-1:1]};
`ifdef ALU_DIV_EN
        DIV: {hi, lo} <= dif[W] ? {r2, lo[W-2:0], 1'b0} : {dif[W-1:0], lo[W-2:0], 1'b1};
`endif
        default: begin
`ifdef ALU_DIV_EN
          if (is_div) {y_hi, y_lo, v, n, z} <= {r_fix, q_fix, ovf, q_fix[W-1], ~|q_fix};
          else
`endif
          {y_hi, y_lo, v, n, z} <= {prod, 1'b0, prod[2*W-1], ~|prod};
          c <= 1'b0;
          done <= 1'b1;
        end
      endcase
    end
  assign bus.busy = state != IDLE;
  assign bus.done = done;
  assign bus.Y_hi = y_hi;
  assign bus.Y_lo = y_lo;
  assign {bus.C, bus.V, bus.N, bus.Z} = {c, v, n, z};
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle at W=32; follows ALU_DIV_EN for opcode 1F
module tb_alu_multicycle;
  localparam int W = 32;
  typedef struct {logic [W-1:0] hi, lo; logic [3:0] f; int lat, due;} exp_t;
  logic clk = 1'b0, reset = 1'b1;
  int cyc = 0, checks = 0, passed = 0, fails = 0;
  bit mon_en = 1'b0;
  exp_t sb[$];
  exp_t head;
  logic [4:0] ops [18] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08,
                           5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h1E, 5'h1F, 5'h13};
  alu_multicycle_if #(.W(W)) bus();
  alu_multicycle #(.W(W)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk(logic [W-1:0] hi, logic [W-1:0] lo, logic [3:0] f, int lat);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.f = f;
    e.lat = lat;
    e.due = 0;
    return e;
  endfunction

  // reference model: flags are {C,V,N,Z}
  function automatic exp_t model(logic [4:0] fs, logic [W-1:0] s, logic [W-1:0] t);
    exp_t e;
    logic [W:0] w;
    logic [2*W-1:0] p;
    logic c, v;
    e = mk('0, '0, 4'b0, 1);
    c = 1'b0;
    v = 1'b0;
    case (fs)
      5'h00: e.lo = s;
      5'h01: e.lo = t;
      5'h02, 5'h03: begin
        w = {1'b0, s} + {1'b0, t};
        e.lo = w[W-1:0];
        c = w[W];
        v = fs == 5'h02 && s[W-1] == t[W-1] && e.lo[W-1] != s[W-1];
      end
      5'h04, 5'h05: begin
        w = {1'b0, s} - {1'b0, t};
        e.lo = w[W-1:0];
        c = ~w[W];
        v = fs == 5'h04 && s[W-1] != t[W-1] && e.lo[W-1] != s[W-1];
      end
      5'h06: e.lo = {31'b0, $signed(s) < $signed(t)};
      5'h07: e.lo = {31'b0, s < t};
      5'h08: e.lo = s & t;
      5'h09: e.lo = s | t;
      5'h0A: e.lo = s ^ t;
      5'h0B: e.lo = ~(s | t);
      5'h0C: e.lo = t << s[4:0];
      5'h0D: e.lo = t >> s[4:0];
      5'h0E: e.lo = $signed(t) >>> s[4:0];
      5'h1E: begin
        p = {{W{s[W-1]}}, s} * {{W{t[W-1]}}, t};
        e = mk(p[2*W-1:W], p[W-1:0], {2'b00, p[2*W-1], p == 0}, W + 2);
      end
      5'h1F:
`ifdef ALU_DIV_EN
        if (t == 0) e = mk(s, '1, 4'b0110, 1);
        else if (s == 32'h8000_0000 && t == '1) e = mk('0, s, 4'b0110, W + 2);
        else begin
          e.lo = $signed(s) / $signed(t);
          e.hi = $signed(s) % $signed(t);
          e.f = {2'b00, e.lo[W-1], e.lo == 0};
          e.lat = W + 2;
        end
`else
        e.f = 4'b0100;
`endif
      default: ;
    endcase
    if (fs <= 5'h0E) e.f = {c, v, e.lo[W-1], e.lo == 0};
    return e;
  endfunction

  always @(negedge clk) if (mon_en) begin
    chk("busy", bus.busy, sb.size() > 0 && sb[0].lat > 1 && cyc > sb[0].due - sb[0].lat && cyc < sb[0].due);
    if (bus.done) begin
      if (sb.size() == 0) chk("spurious done", bus.done, 0);
      else begin
        head = sb.pop_front();
        chk("Y_hi", bus.Y_hi, head.hi);
        chk("Y_lo", bus.Y_lo, head.lo);
        chk("CVNZ", {bus.C, bus.V, bus.N, bus.Z}, head.f);
        chk("done cycle", 64'(cyc), 64'(head.due));
      end
    end
  end

  task automatic issue(logic [4:0] fs, logic [W-1:0] s, logic [W-1:0] t, exp_t e);
    bus.start = 1'b1;
    bus.FS = fs;
    bus.S = s;
    bus.T = t;
    e.due = cyc + e.lat;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    bus.start = 1'b0;
    for (int i = 0; i < 4 * W && sb.size() > 0; i++) @(negedge clk);
    chk("drain timeout", 64'(sb.size()), 0);
    sb.delete();
  endtask

  task automatic busy_starts();
    bus.start = 1'b0;
    @(negedge clk);
    repeat (4) begin
      bus.start = 1'b1;
      bus.FS = 5'h04;
      bus.S = $urandom;
      bus.T = $urandom;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " done"}, bus.done, 0);
    chk({tag, " Y_hi"}, bus.Y_hi, 0);
    chk({tag, " Y_lo"}, bus.Y_lo, 0);
    chk({tag, " CVNZ"}, {bus.C, bus.V, bus.N, bus.Z}, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.FS = '0;
    bus.S = '0;
    bus.T = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;
    issue(5'h02, 32'h7FFF_FFFF, 32'h1, mk('0, 32'h8000_0000, 4'b0110, 1));
    drain();
    issue(5'h1E, -32'sd3, 32'd7, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 4'b0010, W + 2));
    busy_starts();
    drain();
`ifdef ALU_DIV_EN
    issue(5'h1F, -32'sd7, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 4'b0010, W + 2));
    busy_starts();
    drain();
    issue(5'h1F, 32'd5, 32'd0, mk(32'd5, 32'hFFFF_FFFF, 4'b0110, 1));
    drain();
    issue(5'h1F, 32'h8000_0000, 32'hFFFF_FFFF, mk('0, 32'h8000_0000, 4'b0110, W + 2));
    drain();
`else
    issue(5'h1F, 32'd5, 32'd0, mk('0, '0, 4'b0100, 1));
    drain();
`endif
    issue(5'h04, 32'd5, 32'd5, mk('0, '0, 4'b1001, 1));
    issue(5'h05, 32'd3, 32'd5, mk('0, 32'hFFFF_FFFE, 4'b0010, 1));
    issue(5'h04, 32'h8000_0000, 32'd1, mk('0, 32'h7FFF_FFFF, 4'b1100, 1));
    issue(5'h0E, 32'd35, 32'h8000_0000, mk('0, 32'hF000_0000, 4'b0010, 1));
    issue(5'h13, 32'd9, 32'd9, mk('0, '0, 4'b0000, 1));
    drain();
    for (int i = 0; i < 40; i++) begin
      logic [4:0] f;
      logic [W-1:0] a, b;
      exp_t e;
      f = ops[$urandom_range(0, 17)];
      a = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(0, 2)) - 32'd1 : $urandom;
      e = model(f, a, b);
      issue(f, a, b, e);
      if (e.lat > 1) drain();
    end
    drain();
    issue(5'h1E, 32'd12345, 32'd678, model(5'h1E, 32'd12345, 32'd678));
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    mon_en = 1'b0;
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk_zero("mid-op reset");
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (W + 4) @(negedge clk);
    issue(5'h00, 32'h1234, 32'h0, mk('0, 32'h1234, 4'b0000, 1));
    drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
